// File: rtl/traffic_light_nphase_pkg.sv
// Shared types and default timing for the N-phase traffic light controller.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2,
        ST_FLASH   = 2'd3
    } tl_state_e;

    localparam int unsigned DEF_NUM_PHASES        = 2;
    localparam int unsigned DEF_GREEN_CYCLES      = 30;
    localparam int unsigned DEF_YELLOW_CYCLES     = 5;
    localparam int unsigned DEF_RED_RED_CYCLES    = 2;
    localparam int unsigned DEF_FLASH_HALF_CYCLES = 5;
    localparam int unsigned DEF_WALK_CYCLES       = 10;

    // Largest of four durations; sizes the shared down-counter.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_nphase_if.sv
// Lamp/request bundle between the controller (slave) and its environment (master).
interface traffic_light_nphase_if #(
    parameter int unsigned NUM_PHASES = 2
);
    localparam int unsigned PW = $clog2(NUM_PHASES);

    logic                  mode_switch;
    logic [NUM_PHASES-1:0] ped_req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] walk;
    logic [PW-1:0]         phase;

    modport master (
        output mode_switch, ped_req,
        input  red, yellow, green, walk, phase
    );

    modport slave (
        input  mode_switch, ped_req,
        output red, yellow, green, walk, phase
    );

endinterface

// File: rtl/traffic_light_nphase_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset to a chosen value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/traffic_light_nphase.sv
// N-phase traffic light controller: Moore FSM with a shared down-counter,
// sticky pedestrian requests and a flash mode selected by mode_switch.
module traffic_light_nphase
    import traffic_light_pkg::*;
#(
    parameter int unsigned NUM_PHASES        = DEF_NUM_PHASES,
    parameter int unsigned GREEN_CYCLES      = DEF_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
    parameter int unsigned RED_RED_CYCLES    = DEF_RED_RED_CYCLES,
    parameter int unsigned FLASH_HALF_CYCLES = DEF_FLASH_HALF_CYCLES,
    parameter int unsigned WALK_CYCLES       = DEF_WALK_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_nphase_if.slave  bus
);

    localparam int unsigned PW      = $clog2(NUM_PHASES);
    localparam int unsigned MAX_DUR = max4(GREEN_CYCLES, YELLOW_CYCLES,
                                           RED_RED_CYCLES, FLASH_HALF_CYCLES);
    localparam int unsigned CW      = $clog2(MAX_DUR) + 1;

    if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
        $error("NUM_PHASES must be 2..8");
    end
    if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || RED_RED_CYCLES < 1 ||
        FLASH_HALF_CYCLES < 1) begin : g_bad_durations
        $error("all duration parameters must be >= 1");
    end
    if (WALK_CYCLES < 1 || WALK_CYCLES > GREEN_CYCLES) begin : g_bad_walk
        $error("WALK_CYCLES must be 1..GREEN_CYCLES");
    end

    tl_state_e             r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [PW-1:0]         r_phase, w_phase_nxt;
    logic [NUM_PHASES-1:0] r_pending, w_pending_nxt;
    logic                  r_walk_en, w_walk_en_nxt;
    logic                  r_flash_on, w_flash_on_nxt;

    logic                  w_mode_sync;
    logic [NUM_PHASES-1:0] w_req;
    logic [NUM_PHASES-1:0] w_clr;
    logic                  w_last;
    logic                  w_enter_green;
    logic [PW-1:0]         w_green_phase;
    logic [PW-1:0]         w_phase_inc;

    logic [NUM_PHASES-1:0] w_red, w_yellow, w_green, w_walk;

    sync_2ff #(.RESET_VAL(1'b1)) u_mode_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.mode_switch),
        .o_q (w_mode_sync)
    );

    assign w_req       = r_pending | bus.ped_req;
    assign w_last      = (r_cnt == CW'(1));
    assign w_phase_inc = (r_phase == PW'(NUM_PHASES - 1)) ? '0 : r_phase + 1'b1;

    // State, counter, phase and pedestrian registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_GREEN;
            r_cnt      <= CW'(GREEN_CYCLES);
            r_phase    <= '0;
            r_pending  <= '0;
            r_walk_en  <= 1'b0;
            r_flash_on <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_pending  <= w_pending_nxt;
            r_walk_en  <= w_walk_en_nxt;
            r_flash_on <= w_flash_on_nxt;
        end
    end

    // Next-state logic; the counter is reloaded on every state entry and
    // fires the transition on its last count (value 1).
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt - 1'b1;
        w_phase_nxt    = r_phase;
        w_walk_en_nxt  = r_walk_en;
        w_flash_on_nxt = r_flash_on;
        w_enter_green  = 1'b0;
        w_green_phase  = w_phase_inc;
        w_clr          = '0;

        if (!w_mode_sync) begin
            if (r_state != ST_FLASH) begin
                w_state_nxt    = ST_FLASH;
                w_cnt_nxt      = CW'(FLASH_HALF_CYCLES);
                w_flash_on_nxt = 1'b1;
                w_walk_en_nxt  = 1'b0;
            end else if (w_last) begin
                w_cnt_nxt      = CW'(FLASH_HALF_CYCLES);
                w_flash_on_nxt = ~r_flash_on;
            end
        end else begin
            case (r_state)
                ST_GREEN: begin
                    if (w_last) begin
                        w_state_nxt   = ST_YELLOW;
                        w_cnt_nxt     = CW'(YELLOW_CYCLES);
                        w_walk_en_nxt = 1'b0;
                    end
                end
                ST_YELLOW: begin
                    if (w_last) begin
                        w_state_nxt = ST_ALL_RED;
                        w_cnt_nxt   = CW'(RED_RED_CYCLES);
                    end
                end
                ST_ALL_RED: begin
                    if (w_last) w_enter_green = 1'b1;
                end
                ST_FLASH: begin
                    w_enter_green = 1'b1;
                    w_green_phase = '0;
                end
                default: ;
            endcase
        end

        // A request seen on the entry edge is served in this green and consumed.
        if (w_enter_green) begin
            w_state_nxt          = ST_GREEN;
            w_cnt_nxt            = CW'(GREEN_CYCLES);
            w_phase_nxt          = w_green_phase;
            w_walk_en_nxt        = w_req[w_green_phase];
            w_clr[w_green_phase] = 1'b1;
        end

        w_pending_nxt = w_req & ~w_clr;
    end

    // Lamp decode from registered state only.
    always_comb begin
        w_red    = '0;
        w_yellow = '0;
        w_green  = '0;
        w_walk   = '0;
        case (r_state)
            ST_GREEN: begin
                w_red          = '1;
                w_red[r_phase] = 1'b0;
                w_green[r_phase] = 1'b1;
                if (r_walk_en && (r_cnt > CW'(GREEN_CYCLES - WALK_CYCLES)))
                    w_walk[r_phase] = 1'b1;
            end
            ST_YELLOW: begin
                w_red             = '1;
                w_red[r_phase]    = 1'b0;
                w_yellow[r_phase] = 1'b1;
            end
            ST_ALL_RED: w_red    = '1;
            ST_FLASH:   w_yellow = {NUM_PHASES{r_flash_on}};
            default: ;
        endcase
    end

    assign bus.red    = w_red;
    assign bus.yellow = w_yellow;
    assign bus.green  = w_green;
    assign bus.walk   = w_walk;
    assign bus.phase  = r_phase;

endmodule

// File: tb/tb_traffic_light_nphase.sv
// Directed bench for traffic_light_nphase with 3 phases and default timing.
module tb_traffic_light_nphase;

    localparam int unsigned NP = 3;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    traffic_light_nphase_if #(.NUM_PHASES(NP)) tl_if ();

    traffic_light_nphase #(
        .NUM_PHASES        (NP),
        .GREEN_CYCLES      (30),
        .YELLOW_CYCLES     (5),
        .RED_RED_CYCLES    (2),
        .FLASH_HALF_CYCLES (5),
        .WALK_CYCLES       (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tl_if)
    );

    always #5 clk = ~clk;

    // Observed lamps packed as {red, yellow, green, walk, phase}.
    function automatic logic [13:0] obs();
        return {tl_if.red, tl_if.yellow, tl_if.green, tl_if.walk, tl_if.phase};
    endfunction

    function automatic logic [13:0] v(input logic [2:0] r, input logic [2:0] y,
                                      input logic [2:0] g, input logic [2:0] w,
                                      input logic [1:0] p);
        return {r, y, g, w, p};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got r/y/g/w/p=%b_%b_%b_%b_%0d exp=%b_%b_%b_%b_%0d",
                     tag, cyc, got[13:11], got[10:8], got[7:5], got[4:2], got[1:0],
                     exp[13:11], exp[10:8], exp[7:5], exp[4:2], exp[1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int unsigned n);
        while (cyc < n) step();
    endtask

    task automatic at_cyc(input string tag, input int unsigned n, input logic [13:0] e);
        run_to(n);
        check(tag, obs(), e);
    endtask

    // One-cycle request pulse covering the rising edge that ends the current cycle.
    task automatic ped_pulse(input int unsigned idx);
        tl_if.ped_req[idx] = 1'b1;
        step();
        tl_if.ped_req[idx] = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    localparam logic [13:0] G0 = {3'b110, 3'b000, 3'b001, 3'b000, 2'd0};

    initial begin
        rst               = 1'b1;
        tl_if.mode_switch = 1'b1;
        tl_if.ped_req     = '0;
        cyc               = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", obs(), G0);

        // Normal cycling with pedestrian service.
        release_rst();
        at_cyc("g0_first", 0, G0);
        run_to(10);
        ped_pulse(1);
        at_cyc("g0_last", 29, G0);
        at_cyc("y0_first", 30, v(3'b110, 3'b001, 3'b000, 3'b000, 2'd0));
        at_cyc("allred_a", 35, v(3'b111, 3'b000, 3'b000, 3'b000, 2'd0));
        at_cyc("allred_b", 36, v(3'b111, 3'b000, 3'b000, 3'b000, 2'd0));
        at_cyc("g1_walk_first", 37, v(3'b101, 3'b000, 3'b010, 3'b010, 2'd1));
        at_cyc("g1_walk_last", 46, v(3'b101, 3'b000, 3'b010, 3'b010, 2'd1));
        at_cyc("g1_walk_off", 47, v(3'b101, 3'b000, 3'b010, 3'b000, 2'd1));
        at_cyc("y1_first", 67, v(3'b101, 3'b010, 3'b000, 3'b000, 2'd1));
        run_to(73);
        ped_pulse(2);
        at_cyc("g2_entry_walk", 74, v(3'b011, 3'b000, 3'b100, 3'b100, 2'd2));
        run_to(78);
        ped_pulse(2);
        at_cyc("g2_walk_last", 83, v(3'b011, 3'b000, 3'b100, 3'b100, 2'd2));
        at_cyc("g2_not_extended", 84, v(3'b011, 3'b000, 3'b100, 3'b000, 2'd2));
        at_cyc("g0_round2", 111, G0);
        at_cyc("g1_round2_nowalk", 148, v(3'b101, 3'b000, 3'b010, 3'b000, 2'd1));
        at_cyc("g2_round2_walk", 185, v(3'b011, 3'b000, 3'b100, 3'b100, 2'd2));
        at_cyc("g2_round2_walk_off", 195, v(3'b011, 3'b000, 3'b100, 3'b000, 2'd2));

        // Flash entry mid-yellow, request held through flash, resume.
        at_cyc("y0_round3", 252, v(3'b110, 3'b001, 3'b000, 3'b000, 2'd0));
        run_to(253);
        tl_if.mode_switch = 1'b0;
        at_cyc("sync_latency", 255, v(3'b110, 3'b001, 3'b000, 3'b000, 2'd0));
        at_cyc("flash_on_first", 256, v(3'b000, 3'b111, 3'b000, 3'b000, 2'd0));
        at_cyc("flash_on_last", 260, v(3'b000, 3'b111, 3'b000, 3'b000, 2'd0));
        at_cyc("flash_off_first", 261, v(3'b000, 3'b000, 3'b000, 3'b000, 2'd0));
        run_to(262);
        ped_pulse(1);
        at_cyc("flash_off_last", 265, v(3'b000, 3'b000, 3'b000, 3'b000, 2'd0));
        at_cyc("flash_on_again", 266, v(3'b000, 3'b111, 3'b000, 3'b000, 2'd0));
        run_to(268);
        tl_if.mode_switch = 1'b1;
        at_cyc("flash_before_resume", 270, v(3'b000, 3'b111, 3'b000, 3'b000, 2'd0));
        at_cyc("resume_g0_first", 271, G0);
        at_cyc("resume_g0_last", 300, G0);
        at_cyc("resume_y0", 301, v(3'b110, 3'b001, 3'b000, 3'b000, 2'd0));
        at_cyc("flash_ped_walk", 308, v(3'b101, 3'b000, 3'b010, 3'b010, 2'd1));
        at_cyc("flash_ped_walk_last", 317, v(3'b101, 3'b000, 3'b010, 3'b010, 2'd1));
        at_cyc("flash_ped_walk_off", 318, v(3'b101, 3'b000, 3'b010, 3'b000, 2'd1));

        // Asynchronous reset in the middle of phase 1 all-red.
        at_cyc("allred_p1", 343, v(3'b111, 3'b000, 3'b000, 3'b000, 2'd1));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", obs(), G0);
        release_rst();
        at_cyc("rr_g0_first", 0, G0);
        at_cyc("rr_g0_last", 29, G0);
        at_cyc("rr_y0", 30, v(3'b110, 3'b001, 3'b000, 3'b000, 2'd0));
        at_cyc("rr_g1", 37, v(3'b101, 3'b000, 3'b010, 3'b000, 2'd1));
        at_cyc("rr_g2", 74, v(3'b011, 3'b000, 3'b100, 3'b000, 2'd2));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_nphase.md
TRAFFIC_LIGHT_NPHASE -- requirements
Module: traffic_light_nphase

Interface
REQ-001 Parameter NUM_PHASES, default 2: number of signal phases (approaches), legal 2..8.
REQ-002 Parameter GREEN_CYCLES, default 30: clocks per phase green, legal >=1.
REQ-003 Parameter YELLOW_CYCLES, default 5: clocks per phase yellow, legal >=1.
REQ-004 Parameter RED_RED_CYCLES, default 2: all-red clearance clocks after each yellow, legal >=1.
REQ-005 Parameter FLASH_HALF_CYCLES, default 5: flash-mode half period in clocks, legal >=1.
REQ-006 Parameter WALK_CYCLES, default 10: pedestrian walk clocks, legal 1..GREEN_CYCLES.
REQ-007 clk  input  1  system clock, all flops on rising edge.
REQ-008 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-009 mode_switch  input  1  1 = normal cycling, 0 = flash; asynchronous to clk.
REQ-010 ped_req  input  NUM_PHASES  per-phase pedestrian request, single-cycle pulse or level.
REQ-011 red, yellow, green  output  NUM_PHASES each  per-phase lamp drives.
REQ-012 walk  output  NUM_PHASES  per-phase pedestrian walk lamp.
REQ-013 phase  output  $clog2(NUM_PHASES)  index of phase currently owning green/yellow.

Function
REQ-014 The controller SHALL be a Moore FSM with states GREEN, YELLOW, ALL_RED, FLASH; all outputs SHALL be decoded from registered state only.
REQ-015 GREEN SHALL last exactly GREEN_CYCLES clocks, then YELLOW exactly YELLOW_CYCLES, then ALL_RED exactly RED_RED_CYCLES, then GREEN of phase (phase+1) mod NUM_PHASES.
REQ-016 A single down-counter, width $clog2 of the largest duration parameter + 1, SHALL be reloaded on every state entry; transition fires when it reaches its terminal value.
REQ-017 In GREEN/YELLOW, exactly the owning phase SHALL show green/yellow; all other phases SHALL show red; in ALL_RED every phase SHALL show red.
REQ-018 mode_switch SHALL pass through a 2-flop synchroniser; synchronised 0 SHALL force FLASH on the next edge from any state.
REQ-019 In FLASH all yellow bits SHALL toggle together every FLASH_HALF_CYCLES clocks, starting on; red, green, walk SHALL be 0.
REQ-020 Synchronised mode_switch returning to 1 SHALL enter GREEN of phase 0 with a fresh GREEN_CYCLES count.
REQ-021 ped_req[i] high on any edge SHALL set sticky pending[i]; pending bits SHALL be held through FLASH.
REQ-022 On entry to GREEN of phase i, if pending[i] or ped_req[i] is high that cycle, walk[i] SHALL assert for exactly the first WALK_CYCLES clocks of that green and pending[i] SHALL clear.
REQ-023 ped_req[i] arriving after green entry of phase i (including during its walk) SHALL re-set pending[i] for the next service, not extend the current walk.
REQ-024 At most one walk bit SHALL be high at any time; walk SHALL never be high outside GREEN.

Reset
REQ-025 While rst is high, state SHALL be GREEN, phase 0, counter loaded with GREEN_CYCLES, pending cleared, flash toggle cleared, synchroniser flops set to 1.
REQ-026 Reset outputs: green[0]=1, red[others]=1, all yellow=0, walk=0, phase=0, applied asynchronously, including mid-operation.
REQ-027 First green after rst release SHALL last exactly GREEN_CYCLES clocks.

Structure
REQ-028 State encoding enum and default timing constants SHALL live in package traffic_light_pkg.
REQ-029 The mode_switch synchroniser SHALL be sub-module sync_2ff (async active-high reset, parameterised reset value).
REQ-030 Illegal parameter combinations SHALL be caught by elaboration-time checks.

Verification (NUM_PHASES=3, GREEN=30, YELLOW=5, RED_RED=2, FLASH_HALF=5, WALK=10)
REQ-031 Release rst, mode_switch=1 -> green[0] 30 clk, yellow[0] 5, all red 2, green[1] at clk 37, green[2] at 74, green[0] again at 111.
REQ-032 Pulse ped_req[1] during phase 0 green -> walk[1] high exactly clk 37..46, low elsewhere; pending[1] cleared.
REQ-033 ped_req[2] asserted exactly on the GREEN-entry cycle of phase 2 -> walk[2] served in that same green; second pulse mid-walk -> served next round, walk not extended.
REQ-034 mode_switch to 0 mid-YELLOW -> FLASH 2-3 clk later, yellows on 5/off 5, no red/green; mode_switch to 1 -> phase 0 green for full 30 clk.
REQ-035 ped_req[1] during FLASH, then resume -> walk[1] at phase 1 green entry.
REQ-036 Assert rst mid-ALL_RED of phase 1, between clock edges -> outputs switch immediately to reset values; release -> REQ-031 sequence repeats.
